// File: rtl/dynamic_delay_pkg.sv
// Shared helpers for the dynamic delay line.
//   clamp_sel    : limit a requested delay to the legal range 0..length-1
//   ptr_sub_wrap : modular pointer subtraction that works for any depth,
//                  not only powers of two
//   ptr_width    : address width for a buffer of the given depth (at least 1)
package dynamic_delay_pkg;

  function automatic int unsigned clamp_sel(input int unsigned sel,
                                            input int unsigned length);
    return (sel > length - 1) ? length - 1 : sel;
  endfunction

  // Both operands must already lie in 0..length-1.
  function automatic int unsigned ptr_sub_wrap(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned length);
    return (a >= b) ? a - b : a + length - b;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned length);
    return (length < 2) ? 1 : $clog2(length);
  endfunction

endpackage

// File: rtl/dynamic_delay_bus_if.sv
// Bus bundle for dynamic_delay_bus. Signal prefixes follow the DUT's view:
//   i_ena       sample enable
//   i_in        input sample
//   i_sel       requested delay
//   i_sel_load  strobe latching i_sel into the active select
//   o_out       delayed sample (registered)
//   o_out_valid o_out holds a genuine sample from history
//   o_sel_err   one-cycle pulse when a loaded select was clamped
// master drives the stimulus side, slave is the delay line itself.
interface dynamic_delay_bus_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4
);
  logic             i_ena;
  logic [WIDTH-1:0] i_in;
  logic [SEL_W-1:0] i_sel;
  logic             i_sel_load;
  logic [WIDTH-1:0] o_out;
  logic             o_out_valid;
  logic             o_sel_err;

  modport master (
    output i_ena, i_in, i_sel, i_sel_load,
    input  o_out, o_out_valid, o_sel_err
  );

  modport slave (
    input  i_ena, i_in, i_sel, i_sel_load,
    output o_out, o_out_valid, o_sel_err
  );
endinterface

// File: rtl/delay_line_mem.sv
// History buffer for the delay line: simple dual-port RAM, DEPTH x WIDTH,
// one synchronous write port and one combinational read port so it maps onto
// distributed RAM. Contents are never reset.
//   i_clk   clock
//   i_we    write enable
//   i_waddr write address (0..DEPTH-1)
//   i_wdata write data
//   i_raddr read address (0..DEPTH-1)
//   o_rdata read data, combinational from i_raddr
module delay_line_mem #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dynamic_delay_bus.sv
// Runtime-programmable delay line for a WIDTH-bit bus. Each enabled cycle the
// input is written into a circular buffer; the output register takes the
// sample cur_sel enabled cycles older (cur_sel = 0 bypasses the buffer).
// A fill counter keeps o_out_valid low until enough history exists.
//   i_clk  clock, rising edge
//   i_rst  synchronous reset, active high
//   bus    dynamic_delay_bus_if.slave (ena, in, sel, sel_load, out,
//          out_valid, sel_err)
module dynamic_delay_bus
  import dynamic_delay_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LENGTH    = 16,
  parameter int unsigned SEL_W     = $clog2(LENGTH),
  parameter int unsigned RESET_SEL = 0
) (
  input logic                i_clk,
  input logic                i_rst,
  dynamic_delay_bus_if.slave bus
);

  localparam int unsigned PTR_W       = ptr_width(LENGTH);
  localparam int unsigned FILL_W      = $clog2(LENGTH + 1);
  // An illegal RESET_SEL would index outside the buffer, so clamp it here.
  localparam int unsigned RESET_SEL_C = clamp_sel(RESET_SEL, LENGTH);

  logic [PTR_W-1:0]  r_wptr;
  logic [FILL_W-1:0] r_fill;
  logic [PTR_W-1:0]  r_cur_sel;
  logic [WIDTH-1:0]  r_out;
  logic              r_out_valid;
  logic              r_sel_err;

  logic [SEL_W-1:0]  w_sel;
  logic              w_sel_oor;
  logic [PTR_W-1:0]  w_sel_clamped;
  logic [PTR_W-1:0]  w_raddr;
  logic [PTR_W-1:0]  w_wptr_next;
  logic [FILL_W-1:0] w_fill_next;
  logic              w_valid;
  logic              w_we;
  logic [WIDTH-1:0]  w_rdata;
  logic [WIDTH-1:0]  w_tap;

  assign w_sel = bus.i_sel;
  assign w_we  = bus.i_ena & ~i_rst;

  always_comb begin
    w_sel_oor     = 32'(w_sel) > LENGTH - 1;
    w_sel_clamped = PTR_W'(clamp_sel(32'(w_sel), LENGTH));

    // Sample written cur_sel enabled cycles ago.
    w_raddr = PTR_W'(ptr_sub_wrap(32'(r_wptr), 32'(r_cur_sel), LENGTH));

    // Explicit wrap: LENGTH need not be a power of two.
    w_wptr_next = (32'(r_wptr) == LENGTH - 1) ? '0 : r_wptr + PTR_W'(1);

    // Saturates at LENGTH, which already covers every legal cur_sel.
    w_fill_next = (32'(r_fill) == LENGTH) ? r_fill : r_fill + FILL_W'(1);

    // Pre-increment fill: with fill == cur_sel the oldest needed sample exists.
    w_valid = 32'(r_fill) >= 32'(r_cur_sel);

    // cur_sel = 0 reads the address being written this edge, so bypass the RAM.
    w_tap = (r_cur_sel == '0) ? bus.i_in : w_rdata;
  end

  delay_line_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (LENGTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (bus.i_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr      <= '0;
      r_fill      <= '0;
      r_cur_sel   <= PTR_W'(RESET_SEL_C);
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      if (bus.i_ena) begin
        r_wptr      <= w_wptr_next;
        r_fill      <= w_fill_next;
        r_out       <= w_valid ? w_tap : '0;
        r_out_valid <= w_valid;
      end
      // A coincident enabled edge above still used the old select.
      if (bus.i_sel_load) begin
        r_cur_sel <= w_sel_clamped;
      end
      r_sel_err <= bus.i_sel_load & w_sel_oor;
    end
  end

  assign bus.o_out       = r_out;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_sel_err   = r_sel_err;

endmodule
